// File: rtl/rob_commit.sv
// Reorder buffer with in-order, one-per-cycle registered commit.
// Optional taken-branch flush is enabled by defining ROB_BRANCH_FLUSH_EN.
module rob_commit #(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3,
    parameter int DATA_W = 16,
    parameter int FUNC_W = 4,
    parameter int REG_W  = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              alloc_valid,
    input  logic [FUNC_W-1:0] alloc_func,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              cdb_valid,
    input  logic [IDX_W-1:0]  cdb_idx,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              cmt_valid,
    output logic [IDX_W-1:0]  cmt_idx,
    output logic [REG_W-1:0]  cmt_rd,
    output logic [DATA_W-1:0] cmt_data,
    output logic              cmt_reg_we,
    output logic              cmt_mem_we,
    output logic              cmt_flush,
    output logic [IDX_W:0]    count
);

    localparam logic [IDX_W:0]    DEPTH_C   = (IDX_W+1)'(DEPTH);
    localparam logic [FUNC_W-1:0] F_REG_MAX = FUNC_W'(4);
    localparam logic [FUNC_W-1:0] F_STORE   = FUNC_W'(5);
`ifdef ROB_BRANCH_FLUSH_EN
    localparam logic [FUNC_W-1:0] F_BEQ     = FUNC_W'(6);
    localparam logic [FUNC_W-1:0] F_BNEQ    = FUNC_W'(7);
`endif

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  ready_q, ready_d;
    logic [FUNC_W-1:0] func_q [DEPTH];
    logic [FUNC_W-1:0] func_d [DEPTH];
    logic [REG_W-1:0]  rd_q   [DEPTH];
    logic [REG_W-1:0]  rd_d   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [IDX_W:0]    count_q, count_d;

    logic              cmt_valid_q, cmt_valid_d;
    logic [IDX_W-1:0]  cmt_idx_q, cmt_idx_d;
    logic [REG_W-1:0]  cmt_rd_q, cmt_rd_d;
    logic [DATA_W-1:0] cmt_data_q, cmt_data_d;
    logic              cmt_reg_we_q, cmt_reg_we_d;
    logic              cmt_mem_we_q, cmt_mem_we_d;
    logic              cmt_flush_q, cmt_flush_d;

    logic              commit_fire;
    logic              alloc_fire;
    logic              head_taken_br;

    assign commit_fire = valid_q[head_q] && ready_q[head_q];

`ifdef ROB_BRANCH_FLUSH_EN
    assign head_taken_br = commit_fire && data_q[head_q][0] &&
                           ((func_q[head_q] == F_BEQ) || (func_q[head_q] == F_BNEQ));
`else
    assign head_taken_br = 1'b0;
`endif

    // Alloc is blocked while a taken branch sits ready at head so the flush cannot drop it.
    assign alloc_ready = (count_q != DEPTH_C) && !head_taken_br;
    assign alloc_idx   = tail_q;
    assign alloc_fire  = alloc_valid && alloc_ready;

    always_comb begin
        valid_d      = valid_q;
        ready_d      = ready_q;
        func_d       = func_q;
        rd_d         = rd_q;
        data_d       = data_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
        cmt_valid_d  = 1'b0;
        cmt_idx_d    = cmt_idx_q;
        cmt_rd_d     = cmt_rd_q;
        cmt_data_d   = cmt_data_q;
        cmt_reg_we_d = cmt_reg_we_q;
        cmt_mem_we_d = cmt_mem_we_q;
        cmt_flush_d  = 1'b0;

        if (cdb_valid && valid_q[cdb_idx]) begin
            ready_d[cdb_idx] = 1'b1;
            data_d[cdb_idx]  = cdb_data;
        end

        if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            ready_d[tail_q] = 1'b0;
            func_d[tail_q]  = alloc_func;
            rd_d[tail_q]    = alloc_rd;
            tail_d          = tail_q + IDX_W'(1);
        end

        // Commit is applied last so retiring the head wins over a same-edge CDB rewrite.
        if (commit_fire) begin
            cmt_valid_d     = 1'b1;
            cmt_idx_d       = head_q;
            cmt_rd_d        = rd_q[head_q];
            cmt_data_d      = data_q[head_q];
            cmt_reg_we_d    = (func_q[head_q] <= F_REG_MAX);
            cmt_mem_we_d    = (func_q[head_q] == F_STORE);
            valid_d[head_q] = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + IDX_W'(1);
        end

        if (head_taken_br) begin
            cmt_flush_d = 1'b1;
            valid_d     = '0;
            ready_d     = '0;
            tail_d      = head_q + IDX_W'(1);
            count_d     = '0;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            ready_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            cmt_valid_q  <= 1'b0;
            cmt_idx_q    <= '0;
            cmt_rd_q     <= '0;
            cmt_data_q   <= '0;
            cmt_reg_we_q <= 1'b0;
            cmt_mem_we_q <= 1'b0;
            cmt_flush_q  <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            ready_q      <= ready_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            cmt_valid_q  <= cmt_valid_d;
            cmt_idx_q    <= cmt_idx_d;
            cmt_rd_q     <= cmt_rd_d;
            cmt_data_q   <= cmt_data_d;
            cmt_reg_we_q <= cmt_reg_we_d;
            cmt_mem_we_q <= cmt_mem_we_d;
            cmt_flush_q  <= cmt_flush_d;
        end
    end

    // Payload needs no reset; it is only observed through valid/ready.
    always_ff @(posedge clk1) begin
        func_q <= func_d;
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    assign cmt_valid  = cmt_valid_q;
    assign cmt_idx    = cmt_idx_q;
    assign cmt_rd     = cmt_rd_q;
    assign cmt_data   = cmt_data_q;
    assign cmt_reg_we = cmt_reg_we_q;
    assign cmt_mem_we = cmt_mem_we_q;
    assign cmt_flush  = cmt_flush_q;
    assign count      = count_q;

endmodule

// File: tb/tb_rob_commit.sv
// Directed self-checking bench for rob_commit; expectations follow the
// ROB_BRANCH_FLUSH_EN build setting.
module tb_rob_commit;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        alloc_valid;
    logic [3:0]  alloc_func;
    logic [3:0]  alloc_rd;
    logic        alloc_ready;
    logic [2:0]  alloc_idx;
    logic        cdb_valid;
    logic [2:0]  cdb_idx;
    logic [15:0] cdb_data;
    logic        cmt_valid;
    logic [2:0]  cmt_idx;
    logic [3:0]  cmt_rd;
    logic [15:0] cmt_data;
    logic        cmt_reg_we;
    logic        cmt_mem_we;
    logic        cmt_flush;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    rob_commit #(.DEPTH(8), .IDX_W(3), .DATA_W(16), .FUNC_W(4), .REG_W(4)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_data(cdb_data),
        .cmt_valid(cmt_valid), .cmt_idx(cmt_idx), .cmt_rd(cmt_rd), .cmt_data(cmt_data),
        .cmt_reg_we(cmt_reg_we), .cmt_mem_we(cmt_mem_we), .cmt_flush(cmt_flush),
        .count(count)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    // Called 1 time unit after an edge, so the pulse lands mid-cycle.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic alloc(input logic [3:0] f, input logic [3:0] rd);
        alloc_valid = 1'b1;
        alloc_func  = f;
        alloc_rd    = rd;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic cdb(input logic [2:0] idx, input logic [15:0] d);
        cdb_valid = 1'b1;
        cdb_idx   = idx;
        cdb_data  = d;
        step();
        cdb_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        alloc_valid = 1'b0; alloc_func = '0; alloc_rd = '0;
        cdb_valid = 1'b0; cdb_idx = '0; cdb_data = '0;

        // 1: reset state
        #3;
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_cmt_valid", 32'(cmt_valid), 32'd0);
        check("rst_alloc_idx", 32'(alloc_idx), 32'd0);
        check("rst_cmt_flush", 32'(cmt_flush), 32'd0);
        step();
        rst_n = 1'b1;

        // 2: single add
        alloc(4'd0, 4'd3);
        check("t2_count", 32'(count), 32'd1);
        check("t2_alloc_idx", 32'(alloc_idx), 32'd1);
        cdb(3'd0, 16'h00A5);
        check("t2_no_commit_yet", 32'(cmt_valid), 32'd0);
        step();
        check("t2_cmt_valid", 32'(cmt_valid), 32'd1);
        check("t2_cmt_idx", 32'(cmt_idx), 32'd0);
        check("t2_cmt_rd", 32'(cmt_rd), 32'd3);
        check("t2_cmt_data", 32'(cmt_data), 32'h00A5);
        check("t2_reg_we", 32'(cmt_reg_we), 32'd1);
        check("t2_mem_we", 32'(cmt_mem_we), 32'd0);
        check("t2_count_after", 32'(count), 32'd0);
        step();
        check("t2_pulse_end", 32'(cmt_valid), 32'd0);
        check("t2_data_hold", 32'(cmt_data), 32'h00A5);

        // 3: out-of-order CDB, in-order commit
        pulse_reset();
        alloc(4'd1, 4'd1);
        alloc(4'd5, 4'd2);
        alloc(4'd8, 4'd3);
        check("t3_count", 32'(count), 32'd3);
        cdb(3'd2, 16'h0222);
        check("t3_hold_a", 32'(cmt_valid), 32'd0);
        cdb(3'd1, 16'h0111);
        check("t3_hold_b", 32'(cmt_valid), 32'd0);
        cdb(3'd0, 16'h0100);
        check("t3_hold_c", 32'(cmt_valid), 32'd0);
        step();
        check("t3_c0_valid", 32'(cmt_valid), 32'd1);
        check("t3_c0_idx", 32'(cmt_idx), 32'd0);
        check("t3_c0_data", 32'(cmt_data), 32'h0100);
        check("t3_c0_reg_we", 32'(cmt_reg_we), 32'd1);
        step();
        check("t3_c1_valid", 32'(cmt_valid), 32'd1);
        check("t3_c1_idx", 32'(cmt_idx), 32'd1);
        check("t3_c1_data", 32'(cmt_data), 32'h0111);
        check("t3_c1_reg_we", 32'(cmt_reg_we), 32'd0);
        check("t3_c1_mem_we", 32'(cmt_mem_we), 32'd1);
        step();
        check("t3_c2_valid", 32'(cmt_valid), 32'd1);
        check("t3_c2_idx", 32'(cmt_idx), 32'd2);
        check("t3_c2_rd", 32'(cmt_rd), 32'd3);
        check("t3_c2_reg_we", 32'(cmt_reg_we), 32'd0);
        check("t3_c2_mem_we", 32'(cmt_mem_we), 32'd0);
        check("t3_count_end", 32'(count), 32'd0);
        step();
        check("t3_idle", 32'(cmt_valid), 32'd0);

        // 4: full, held alloc, wrap
        pulse_reset();
        for (int i = 0; i < 8; i++) alloc(4'd0, 4'(i));
        check("t4_count_full", 32'(count), 32'd8);
        check("t4_not_ready", 32'(alloc_ready), 32'd0);
        check("t4_idx_wrap", 32'(alloc_idx), 32'd0);
        alloc_valid = 1'b1;
        alloc_func  = 4'd0;
        alloc_rd    = 4'd9;
        cdb_valid = 1'b1; cdb_idx = 3'd0; cdb_data = 16'h1234;
        step();
        cdb_valid = 1'b0;
        check("t4_held_count", 32'(count), 32'd8);
        check("t4_held_ready", 32'(alloc_ready), 32'd0);
        step();
        check("t4_commit_valid", 32'(cmt_valid), 32'd1);
        check("t4_commit_data", 32'(cmt_data), 32'h1234);
        check("t4_count_after_commit", 32'(count), 32'd7);
        check("t4_ready_again", 32'(alloc_ready), 32'd1);
        check("t4_alloc_idx", 32'(alloc_idx), 32'd0);
        step();
        alloc_valid = 1'b0;
        check("t4_refill_count", 32'(count), 32'd8);
        check("t4_refill_idx", 32'(alloc_idx), 32'd1);
        check("t4_refill_ready", 32'(alloc_ready), 32'd0);

        // 5: taken branch at head
        pulse_reset();
        alloc(4'd6, 4'd0);
        alloc(4'd2, 4'd5);
        cdb(3'd1, 16'h0055);
        cdb(3'd0, 16'h0001);
`ifdef ROB_BRANCH_FLUSH_EN
        check("t5_alloc_blocked", 32'(alloc_ready), 32'd0);
`else
        check("t5_alloc_open", 32'(alloc_ready), 32'd1);
`endif
        step();
        check("t5_br_valid", 32'(cmt_valid), 32'd1);
        check("t5_br_idx", 32'(cmt_idx), 32'd0);
        check("t5_br_reg_we", 32'(cmt_reg_we), 32'd0);
        check("t5_br_mem_we", 32'(cmt_mem_we), 32'd0);
`ifdef ROB_BRANCH_FLUSH_EN
        check("t5_flush", 32'(cmt_flush), 32'd1);
        check("t5_count_flushed", 32'(count), 32'd0);
        check("t5_alloc_idx", 32'(alloc_idx), 32'd1);
        step();
        check("t5_no_idx1", 32'(cmt_valid), 32'd0);
        check("t5_flush_end", 32'(cmt_flush), 32'd0);
        check("t5_count_end", 32'(count), 32'd0);
`else
        check("t5_flush", 32'(cmt_flush), 32'd0);
        check("t5_count", 32'(count), 32'd1);
        step();
        check("t5_idx1_valid", 32'(cmt_valid), 32'd1);
        check("t5_idx1_idx", 32'(cmt_idx), 32'd1);
        check("t5_idx1_data", 32'(cmt_data), 32'h0055);
        check("t5_idx1_reg_we", 32'(cmt_reg_we), 32'd1);
        check("t5_count_end", 32'(count), 32'd0);
`endif

        // 6: async reset with work in flight
        pulse_reset();
        for (int i = 0; i < 4; i++) alloc(4'd0, 4'(i));
        cdb(3'd1, 16'h0BAD);
        cdb(3'd0, 16'h0ACE);
        step();
        check("t6_pre_valid", 32'(cmt_valid), 32'd1);
        check("t6_pre_count", 32'(count), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_cmt_valid", 32'(cmt_valid), 32'd0);
        check("t6_rst_alloc_idx", 32'(alloc_idx), 32'd0);
        #1;
        rst_n = 1'b1;
        cdb(3'd2, 16'h7777);
        check("t6_ghost_count", 32'(count), 32'd0);
        step();
        check("t6_ghost_commit", 32'(cmt_valid), 32'd0);
        cdb(3'd0, 16'h5555);
        alloc(4'd0, 4'd7);
        step();
        check("t6_stale_not_ready", 32'(cmt_valid), 32'd0);
        check("t6_count_one", 32'(count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
